traffic_queue_gen: RTL and testbench

TRAFFIC_QUEUE_GEN -- requirements
Module: TRAFFIC_QUEUE_GEN

---
 rtl/traffic_queue_gen.sv | 237 +++++++++++++++++++++++
 tb/tb_traffic_queue_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_queue_gen.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_queue_gen (with helper traffic_queue_gen_road)
//  Purpose  : Two-road traffic queue generator. A shared tick divider paces
//             per-road LFSR-driven arrivals and light-driven departures
//             through a STOPPED/STARTUP/FLOWING discharge FSM.
//  Options  : TQG_OVERRIDE_EN - adds LOAD_VALID/LOAD_MAIN/LOAD_COUNTRY to
//             force both queue depths (reset still wins).
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// One road: arrival LFSR, discharge FSM and saturating 0..7 queue.
// ----------------------------------------------------------------------------
module traffic_queue_gen_road #(
    parameter logic [15:0] SEED          = 16'h0001,
    parameter logic [7:0]  THRESH        = 8'd0,
    parameter int unsigned STARTUP_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [1:0] light,
    input  logic       load_valid,
    input  logic [2:0] load_value,
    output logic [2:0] traffic
);

    localparam logic [1:0]  c_st_stopped = 2'd0;
    localparam logic [1:0]  c_st_startup = 2'd1;
    localparam logic [1:0]  c_st_flowing = 2'd2;

    // Galois taps for x^16+x^14+x^13+x^11+1 in right-shift form.
    localparam logic [15:0] c_lfsr_taps  = 16'hB400;
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] c_seed       = (SEED == 16'h0000) ? 16'h0001 : SEED;
    // The GREEN tick that leaves STOPPED is already the first startup tick,
    // so STARTUP only has to wait for the remaining STARTUP_TICKS-1.
    localparam logic        c_skip_startup = (STARTUP_TICKS <= 1);
    localparam logic [3:0]  c_startup_load = (STARTUP_TICKS > 1) ? 4'(STARTUP_TICKS - 1) : 4'd0;
    localparam logic [2:0]  c_q_max      = 3'd7;

    logic [15:0] r_lfsr;
    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_traffic;

    logic        w_green;
    logic        w_red;
    logic        w_arrival;
    logic        w_departure;
    logic [15:0] w_lfsr_nxt;
    logic [1:0]  w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [2:0]  w_traffic_nxt;

    // Light decode: 11 is treated the same as RED.
    assign w_green = (light == 2'b00);
    assign w_red   = light[1];

    // Sample for this tick is taken from the current LFSR value.
    assign w_arrival   = (r_lfsr[7:0] < THRESH);
    // Departures look at the pre-transition state.
    assign w_departure = (r_state == c_st_flowing) && (r_traffic != 3'd0);

    // Galois LFSR advance.
    assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_lfsr_taps : 16'h0000);

    // Discharge FSM next-state, used only when a tick fires.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_stopped: begin
                if (w_green) begin
                    if (c_skip_startup) begin
                        w_state_nxt = c_st_flowing;
                    end else begin
                        w_state_nxt = c_st_startup;
                        w_cnt_nxt   = c_startup_load;
                    end
                end
            end
            c_st_startup: begin
                if (w_green) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = c_st_flowing;
                    end
                end else begin
                    w_state_nxt = c_st_stopped;
                end
            end
            c_st_flowing: begin
                if (w_red) begin
                    w_state_nxt = c_st_stopped;
                end
            end
            default: begin
                w_state_nxt = c_st_stopped;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Queue update: a simultaneous arrival and departure cancel out.
    always_comb begin
        w_traffic_nxt = r_traffic;
        if (w_arrival && !w_departure) begin
            if (r_traffic != c_q_max) begin
                w_traffic_nxt = r_traffic + 3'd1;
            end
        end else if (w_departure && !w_arrival) begin
            w_traffic_nxt = r_traffic - 3'd1;
        end
    end

    // Road state registers; a load only touches the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr    <= c_seed;
            r_state   <= c_st_stopped;
            r_cnt     <= 4'd0;
            r_traffic <= 3'd0;
        end else begin
            if (tick) begin
                r_lfsr  <= w_lfsr_nxt;
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
            if (load_valid) begin
                r_traffic <= load_value;
            end else if (tick) begin
                r_traffic <= w_traffic_nxt;
            end
        end
    end

    assign traffic = r_traffic;

endmodule

// ----------------------------------------------------------------------------
// Top level: tick divider plus two independent roads.
// ----------------------------------------------------------------------------
module traffic_queue_gen #(
    parameter int unsigned TICK_DIV       = 30,
    parameter int unsigned STARTUP_TICKS  = 2,
    parameter logic [15:0] MAIN_SEED      = 16'hACE1,
    parameter logic [15:0] COUNTRY_SEED   = 16'h1D2B,
    parameter logic [7:0]  MAIN_THRESH    = 8'd96,
    parameter logic [7:0]  COUNTRY_THRESH = 8'd32
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic [1:0] MAINLIGHT,
    input  logic [1:0] COUNTRYLIGHT,
`ifdef TQG_OVERRIDE_EN
    input  logic       LOAD_VALID,
    input  logic [2:0] LOAD_MAIN,
    input  logic [2:0] LOAD_COUNTRY,
`endif
    output logic [2:0] MAIN_TRAFFIC,
    output logic [2:0] COUNTRY_TRAFFIC,
    output logic       TICK
);

    localparam logic [15:0] c_tick_last = 16'(TICK_DIV - 1);

    logic [15:0] r_tick_cnt;
    // Registered flag mirroring (r_tick_cnt == c_tick_last).
    logic        r_tick_hit;
    logic [15:0] w_tick_cnt_nxt;
    logic        w_tick;

    logic        w_load_valid;
    logic [2:0]  w_load_main;
    logic [2:0]  w_load_country;

`ifdef TQG_OVERRIDE_EN
    assign w_load_valid   = LOAD_VALID;
    assign w_load_main    = LOAD_MAIN;
    assign w_load_country = LOAD_COUNTRY;
`else
    assign w_load_valid   = 1'b0;
    assign w_load_main    = 3'd0;
    assign w_load_country = 3'd0;
`endif

    assign w_tick_cnt_nxt = r_tick_hit ? 16'd0 : (r_tick_cnt + 16'd1);

    // Tick divider; frozen while EN is low so a pending tick survives a pause.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_tick_cnt <= 16'd0;
            r_tick_hit <= (c_tick_last == 16'd0);
        end else if (EN) begin
            r_tick_cnt <= w_tick_cnt_nxt;
            r_tick_hit <= (w_tick_cnt_nxt == c_tick_last);
        end
    end

    // The tick only fires while running, so TICK reads 0 during a pause.
    assign w_tick = r_tick_hit & EN;
    assign TICK   = w_tick;

    traffic_queue_gen_road #(
        .SEED          (MAIN_SEED),
        .THRESH        (MAIN_THRESH),
        .STARTUP_TICKS (STARTUP_TICKS)
    ) u_main_road (
        .clk        (CLK),
        .rst_n      (RST_N),
        .tick       (w_tick),
        .light      (MAINLIGHT),
        .load_valid (w_load_valid),
        .load_value (w_load_main),
        .traffic    (MAIN_TRAFFIC)
    );

    traffic_queue_gen_road #(
        .SEED          (COUNTRY_SEED),
        .THRESH        (COUNTRY_THRESH),
        .STARTUP_TICKS (STARTUP_TICKS)
    ) u_country_road (
        .clk        (CLK),
        .rst_n      (RST_N),
        .tick       (w_tick),
        .light      (COUNTRYLIGHT),
        .load_valid (w_load_valid),
        .load_value (w_load_country),
        .traffic    (COUNTRY_TRAFFIC)
    );

endmodule
`default_nettype wire

// File: tb/tb_traffic_queue_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_queue_gen
//  Purpose  : Self-checking bench for traffic_queue_gen: hand-written tick
//             table, directed multi-cycle sequences and randomized stimulus
//             compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_queue_gen;

    localparam int          TICK_DIV       = 4;
    localparam int          STARTUP_TICKS  = 2;
    localparam logic [15:0] MAIN_SEED      = 16'hACE1;
    localparam logic [15:0] COUNTRY_SEED   = 16'h1D2B;
    localparam logic [7:0]  MAIN_THRESH    = 8'd96;
    localparam logic [7:0]  COUNTRY_THRESH = 8'd32;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] main_light;
    logic [1:0] country_light;
    logic [2:0] main_q;
    logic [2:0] country_q;
    logic       tick;
`ifdef TQG_OVERRIDE_EN
    logic       load_valid   = 1'b0;
    logic [2:0] load_main    = 3'd0;
    logic [2:0] load_country = 3'd0;
`endif

    always #5 clk = ~clk;

    traffic_queue_gen #(
        .TICK_DIV       (TICK_DIV),
        .STARTUP_TICKS  (STARTUP_TICKS),
        .MAIN_SEED      (MAIN_SEED),
        .COUNTRY_SEED   (COUNTRY_SEED),
        .MAIN_THRESH    (MAIN_THRESH),
        .COUNTRY_THRESH (COUNTRY_THRESH)
    ) dut (
        .CLK             (clk),
        .RST_N           (rst_n),
        .EN              (en),
        .MAINLIGHT       (main_light),
        .COUNTRYLIGHT    (country_light),
`ifdef TQG_OVERRIDE_EN
        .LOAD_VALID      (load_valid),
        .LOAD_MAIN       (load_main),
        .LOAD_COUNTRY    (load_country),
`endif
        .MAIN_TRAFFIC    (main_q),
        .COUNTRY_TRAFFIC (country_q),
        .TICK            (tick)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- behavioural reference model ----------------
    int          m_en_cycles;   // enabled cycles since reset
    int          m_q[2];
    bit          m_flowing[2];
    int          m_green_run[2]; // consecutive GREEN ticks while not flowing
    logic [15:0] m_lfsr[2];
    logic [7:0]  m_thresh[2];
    logic [15:0] m_seed[2];

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic bit model_tick_now(input bit e);
        return e && ((m_en_cycles % TICK_DIV) == TICK_DIV - 1);
    endfunction

    task automatic model_reset();
        m_en_cycles = 0;
        for (int r = 0; r < 2; r++) begin
            m_q[r]         = 0;
            m_flowing[r]   = 1'b0;
            m_green_run[r] = 0;
            m_lfsr[r]      = m_seed[r];
        end
    endtask

    task automatic road_tick(input int r, input logic [1:0] light);
        logic [7:0] low;
        bit arr, dep;
        int need;
        low  = m_lfsr[r][7:0];
        arr  = (low < m_thresh[r]);
        dep  = m_flowing[r] && (m_q[r] > 0);
        m_lfsr[r] = lfsr_adv(m_lfsr[r]);
        need = (STARTUP_TICKS > 1) ? STARTUP_TICKS : 1;
        if (m_flowing[r]) begin
            if (light[1]) m_flowing[r] = 1'b0;
        end else if (light == GREEN) begin
            m_green_run[r]++;
            if (m_green_run[r] >= need) begin
                m_flowing[r]   = 1'b1;
                m_green_run[r] = 0;
            end
        end else begin
            m_green_run[r] = 0;
        end
        if (arr && !dep) m_q[r] = (m_q[r] < 7) ? m_q[r] + 1 : 7;
        else if (dep && !arr) m_q[r] = m_q[r] - 1;
    endtask

    task automatic model_edge(input bit r_n, input bit e, input logic [1:0] a, input logic [1:0] b);
        if (!r_n) begin
            model_reset();
        end else if (e) begin
            if (model_tick_now(1'b1)) begin
                road_tick(0, a);
                road_tick(1, b);
            end
            m_en_cycles++;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare outputs against the model, clock, advance model.
    task automatic step(input bit r_n, input bit e, input logic [1:0] a, input logic [1:0] b,
                        output logic obs_tick);
        rst_n = r_n; en = e; main_light = a; country_light = b;
        #1;
        obs_tick = tick;
        check("tick", {15'd0, tick}, {15'd0, model_tick_now(e)});
        check("main_traffic", {13'd0, main_q}, 16'(m_q[0]));
        check("country_traffic", {13'd0, country_q}, 16'(m_q[1]));
        @(posedge clk);
        model_edge(r_n, e, a, b);
        #1;
    endtask

    task automatic run_cycles(input int n, input bit e, input logic [1:0] a, input logic [1:0] b);
        logic t;
        for (int i = 0; i < n; i++) step(1'b1, e, a, b, t);
    endtask

    typedef struct {
        logic       en;
        logic [1:0] ml;
        logic [1:0] cl;
        logic       exp_tick;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic t;
        logic [2:0] rec_main, rec_country;

        m_seed[0]   = MAIN_SEED;    m_seed[1]   = COUNTRY_SEED;
        m_thresh[0] = MAIN_THRESH;  m_thresh[1] = COUNTRY_THRESH;

        // Tick timing after reset release, including pauses on a pending tick.
        tbl[0]  = '{1'b1, RED, RED, 1'b0};
        tbl[1]  = '{1'b1, RED, RED, 1'b0};
        tbl[2]  = '{1'b1, RED, RED, 1'b0};
        tbl[3]  = '{1'b1, RED, RED, 1'b1};
        tbl[4]  = '{1'b1, RED, RED, 1'b0};
        tbl[5]  = '{1'b0, RED, RED, 1'b0};
        tbl[6]  = '{1'b0, RED, RED, 1'b0};
        tbl[7]  = '{1'b1, RED, RED, 1'b0};
        tbl[8]  = '{1'b1, RED, RED, 1'b0};
        tbl[9]  = '{1'b0, RED, RED, 1'b0};
        tbl[10] = '{1'b0, RED, RED, 1'b0};
        tbl[11] = '{1'b1, RED, RED, 1'b1};
        tbl[12] = '{1'b1, RED, RED, 1'b0};
        tbl[13] = '{1'b1, RED, RED, 1'b0};

        // Reset held for two cycles with EN high.
        rst_n = 1'b0; en = 1'b1; main_light = RED; country_light = RED;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;
        #1;
        check("reset_main", {13'd0, main_q}, 16'd0);
        check("reset_country", {13'd0, country_q}, 16'd0);
        check("reset_tick", {15'd0, tick}, 16'd0);

        for (int i = 0; i < 14; i++) begin
            step(1'b1, tbl[i].en, tbl[i].ml, tbl[i].cl, t);
            check($sformatf("table_tick[%0d]", i), {15'd0, t}, {15'd0, tbl[i].exp_tick});
        end

        // Fresh start so 4-cycle groups line up with ticks.
        step(1'b0, 1'b1, RED, RED, t);

        // Main held RED long enough to saturate; country flows meanwhile.
        run_cycles(60 * TICK_DIV, 1'b1, RED, GREEN);
        check("main_saturated", {13'd0, main_q}, 16'd7);

        // GREEN one tick, YELLOW interrupts STARTUP, then GREEN again.
        run_cycles(TICK_DIV, 1'b1, GREEN, RED);
        run_cycles(TICK_DIV, 1'b1, YELLOW, RED);
        rec_main = main_q;
        run_cycles(2 * TICK_DIV, 1'b1, GREEN, RED);
        check("startup_restart_no_departure", {15'd0, (main_q >= rec_main)}, 16'd1);
        run_cycles(3 * TICK_DIV, 1'b1, GREEN, RED);

        // Reset pulse while main is flowing, mid tick period.
        run_cycles(2, 1'b1, GREEN, RED);
        step(1'b0, 1'b1, GREEN, RED, t);
        check("midflow_reset_main", {13'd0, main_q}, 16'd0);
        check("midflow_reset_country", {13'd0, country_q}, 16'd0);
        run_cycles(10 * TICK_DIV + 1, 1'b1, GREEN, YELLOW);

        // 50-cycle pause mid-run.
        run_cycles(2, 1'b1, RED, GREEN);
        rec_main = main_q; rec_country = country_q;
        run_cycles(50, 1'b0, GREEN, RED);
        check("freeze_main", {13'd0, main_q}, {13'd0, rec_main});
        check("freeze_country", {13'd0, country_q}, {13'd0, rec_country});
        run_cycles(20 * TICK_DIV, 1'b1, RED, GREEN);

        // Randomized run against the model.
        begin
            logic [1:0] a, b;
            bit e, r_n;
            a = GREEN; b = RED;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 5) == 0) a = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 5) == 0) b = 2'($urandom_range(0, 3));
                e   = ($urandom_range(0, 9) != 0);
                r_n = ($urandom_range(0, 299) != 0);
                step(r_n, e, a, b, t);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
